// File: rtl/pc_incrementer_if.sv
// PC incrementer bus: the PC to be advanced, the registered next PC and its overflow flag.
// The datapath side drives old_PC (master); the incrementer drives the results (slave).
interface pc_incrementer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] old_PC;
    logic [WIDTH-1:0] new_PC;
    logic             pc_wrap;

    modport master (output old_PC, input  new_PC, input  pc_wrap);
    modport slave  (input  old_PC, output new_PC, output pc_wrap);
endinterface

// File: rtl/pc_incrementer.sv
// Registered program-counter incrementer: new_PC = old_PC + STEP one clock after sampling,
// with pc_wrap reporting the carry out of the WIDTH-bit addition.
module pc_incrementer #(
    parameter int               WIDTH       = 16,
    parameter int unsigned      STEP        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_incrementer_if.slave    bus
);

    // One extra bit so the carry out lands in sum[WIDTH] instead of being lost.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, bus.old_PC} + STEP_EXT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset branch also clears any in-flight result at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.new_PC  <= RESET_VALUE;
            bus.pc_wrap <= 1'b0;
        end else begin
            bus.new_PC  <= sum[WIDTH-1:0];
            bus.pc_wrap <= sum[WIDTH];
        end
    end

endmodule

// File: tb/tb_pc_incrementer.sv
// Scoreboard bench for pc_incrementer: a default instance (STEP=1, reset 0) and a
// variant (STEP=2, reset 0x0100), each optionally wired in the old_PC <= new_PC loop.
module tb_pc_incrementer;

    typedef struct packed {
        logic [15:0] pc;
        logic        wrap;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fb    = 1'b0;
    logic        fb2   = 1'b0;
    logic [15:0] drv_pc  = 16'h1234;
    logic [15:0] drv_pc2 = 16'h0000;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    pc_incrementer_if #(.WIDTH(16)) bus  ();
    pc_incrementer_if #(.WIDTH(16)) bus2 ();

    assign bus.old_PC  = fb  ? bus.new_PC  : drv_pc;
    assign bus2.old_PC = fb2 ? bus2.new_PC : drv_pc2;

    pc_incrementer #(.WIDTH(16), .STEP(1), .RESET_VALUE(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_incrementer #(.WIDTH(16), .STEP(2), .RESET_VALUE(16'h0100)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] pc, input logic wrap);
        exp_t e;
        e.pc   = pc;
        e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic push2(input logic [15:0] pc, input logic wrap);
        exp_t e;
        e.pc   = pc;
        e.wrap = wrap;
        sb2.push_back(e);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        fb     = 1'b0;
        drv_pc = 16'h1234;
        #1;
        checks++;
        if (bus.new_PC !== 16'h0000 || bus.pc_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_t0: new_PC=%h pc_wrap=%b expected 0000 0", bus.new_PC, bus.pc_wrap);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.new_PC !== 16'h0000 || bus.pc_wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: new_PC=%h pc_wrap=%b expected 0000 0",
                         i, bus.new_PC, bus.pc_wrap);
            end
            checks++;
            if (bus2.new_PC !== 16'h0100 || bus2.pc_wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_variant[%0d]: new_PC=%h pc_wrap=%b expected 0100 0",
                         i, bus2.new_PC, bus2.pc_wrap);
            end
        end
    endtask

    task automatic test_single_increment();
        exp_t e;
        @(negedge clk);
        drv_pc = 16'h0000;
        rst_n  = 1'b1;
        push(16'h0001, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL single_inc: new_PC=%h pc_wrap=%b expected %h %b",
                     bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL single_inc_negedge: new_PC=%h pc_wrap=%b expected %h %b",
                     bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        @(negedge clk);
        drv_pc = 16'hFFFF;
        push(16'h0000, 1'b1);
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL wrap: new_PC=%h pc_wrap=%b expected %h %b",
                     bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
        end
        @(negedge clk);
        drv_pc = 16'h0000;
        push(16'h0001, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL wrap_clear: new_PC=%h pc_wrap=%b expected %h %b",
                     bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
        end
    endtask

    task automatic test_sampling();
        exp_t e;
        logic [15:0] seq [4];
        seq[0] = 16'h1111;
        seq[1] = 16'hABCD;
        seq[2] = 16'hFFFF;
        seq[3] = 16'h7FFE;
        @(negedge clk);
        foreach (seq[i]) begin
            drv_pc = seq[i];
            #1;
            checks++;
            if (bus.new_PC !== 16'h0001 || bus.pc_wrap !== 1'b0) begin
                errors++;
                $display("FAIL sample_hold[%0d]: new_PC=%h pc_wrap=%b expected 0001 0",
                         i, bus.new_PC, bus.pc_wrap);
            end
        end
        push(16'h7FFF, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL sample_edge: new_PC=%h pc_wrap=%b expected %h %b",
                     bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.new_PC !== 16'h0000 || bus.pc_wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: new_PC=%h pc_wrap=%b expected 0000 0",
                     bus.new_PC, bus.pc_wrap);
        end
    endtask

    task automatic test_feedback();
        exp_t        e;
        logic [15:0] model;
        rst_n = 1'b0;
        fb    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            model = model + 16'h0001;
            push(model, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
                errors++;
                $display("FAIL feedback[%0d]: new_PC=%h pc_wrap=%b expected %h %b",
                         i, bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
            end
        end
        checks++;
        if (bus.new_PC !== 16'h0014) begin
            errors++;
            $display("FAIL feedback_final: new_PC=%h expected 0014", bus.new_PC);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.new_PC !== 16'h0000 || bus.pc_wrap !== 1'b0) begin
            errors++;
            $display("FAIL feedback_reset: new_PC=%h pc_wrap=%b expected 0000 0",
                     bus.new_PC, bus.pc_wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            model = model + 16'h0001;
            push(model, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.new_PC !== e.pc || bus.pc_wrap !== e.wrap) begin
                errors++;
                $display("FAIL feedback_restart[%0d]: new_PC=%h pc_wrap=%b expected %h %b",
                         i, bus.new_PC, bus.pc_wrap, e.pc, e.wrap);
            end
        end
        fb = 1'b0;
    endtask

    task automatic test_param_variant();
        exp_t e;
        rst_n = 1'b0;
        fb2   = 1'b1;
        #1;
        checks++;
        if (bus2.new_PC !== 16'h0100 || bus2.pc_wrap !== 1'b0) begin
            errors++;
            $display("FAIL variant_reset: new_PC=%h pc_wrap=%b expected 0100 0",
                     bus2.new_PC, bus2.pc_wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push2(16'h0102, 1'b0);
        push2(16'h0104, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb2.pop_front();
            checks++;
            if (bus2.new_PC !== e.pc || bus2.pc_wrap !== e.wrap) begin
                errors++;
                $display("FAIL variant_feedback[%0d]: new_PC=%h pc_wrap=%b expected %h %b",
                         i, bus2.new_PC, bus2.pc_wrap, e.pc, e.wrap);
            end
        end
        @(negedge clk);
        fb2     = 1'b0;
        drv_pc2 = 16'hFFFF;
        push2(16'h0001, 1'b1);
        tick();
        e = sb2.pop_front();
        checks++;
        if (bus2.new_PC !== e.pc || bus2.pc_wrap !== e.wrap) begin
            errors++;
            $display("FAIL variant_wrap: new_PC=%h pc_wrap=%b expected %h %b",
                     bus2.new_PC, bus2.pc_wrap, e.pc, e.wrap);
        end
    endtask

    initial begin
        test_reset();
        test_single_increment();
        test_wrap();
        test_sampling();
        test_async_reset();
        test_feedback();
        test_param_variant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_incrementer.md
Name: pc_incrementer

Overview:
Registered program-counter incrementer for the 16-bit processor datapath. Each rising clock edge it samples the current PC and presents PC + STEP on its output one cycle later. It sits between the PC register/next-PC mux and the instruction-fetch path. In the simplest loop, new_PC is fed straight back to old_PC, so the PC advances by STEP every clock.

Parameters:
- WIDTH, 16: PC width in bits.
- STEP, 1: increment added each cycle. Word-addressed memory, so the default is 1. Must satisfy 1 <= STEP < 2^WIDTH.
- RESET_VALUE, 0: value driven on new_PC while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- old_PC  input  WIDTH  current PC value to be incremented.
- new_PC  output  WIDTH  registered result, old_PC + STEP.
- pc_wrap  output  1  registered flag; 1 when the last increment overflowed WIDTH bits.

Behaviour:
- Reset:
  - rst_n low forces new_PC = RESET_VALUE and pc_wrap = 0 immediately, independent of clk.
  - Outputs hold these values while rst_n is low.
- Reset release:
  - Release is synchronous in effect: the first update occurs on the first rising clk edge after rst_n goes high.
  - Reset asserted mid-operation clears the outputs immediately and discards any in-flight value.
- Update, on each rising clk edge with rst_n high:
  - new_PC <= (old_PC + STEP) mod 2^WIDTH.
  - pc_wrap <= carry-out of that addition.
- Latency: exactly 1 clock from old_PC sampled to new_PC valid. Outputs are stable between rising edges.
- No combinational path from old_PC to any output. old_PC may change at any time; only its value at the rising edge matters.
- Wrap-around: old_PC = 0xFFFF with STEP = 1 gives new_PC = 0x0000 and pc_wrap = 1 for that cycle. pc_wrap returns to 0 on the next edge without overflow.
- Feedback loop: with old_PC tied to new_PC, the sequence after reset is RESET_VALUE, RESET_VALUE+STEP, RESET_VALUE+2·STEP, … with one step per rising edge.
- Falling edges have no effect.
- Width rule: the addition is performed at WIDTH+1 bits. The low WIDTH bits go to new_PC; the MSB goes to pc_wrap.
- No X propagation from reset: outputs are defined from time zero once rst_n has been low.

Test Plan:
- Reset:
  - Hold rst_n=0, toggle clk, old_PC=0x1234 → new_PC=0x0000, pc_wrap=0 throughout.
  - Assert rst_n=0 between edges → outputs clear immediately, without waiting for a clock edge.
- Single increment: rst_n=1, old_PC=0x0000, one rising edge → new_PC=0x0001, pc_wrap=0. Unchanged after a falling edge.
- Feedback run:
  - Tie old_PC=new_PC, release reset, apply 20 rising edges → new_PC counts 1..20 (0x0014), one step per edge.
  - Reassert rst_n mid-run → new_PC=0 at once. Counting restarts from 1 after release.
- Wrap:
  - old_PC=0xFFFF, edge → new_PC=0x0000, pc_wrap=1.
  - Next edge with old_PC=0x0000 → new_PC=0x0001, pc_wrap=0.
- Arbitrary sampling: change old_PC several times between edges, final value 0x7FFE before edge → new_PC=0x7FFF. No output change between edges.
- Parameter variant: STEP=2, RESET_VALUE=0x0100, feedback loop → 0x0100, 0x0102, 0x0104 on successive edges. old_PC=0xFFFF gives new_PC=0x0001, pc_wrap=1.
